// File: rtl/mips_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the grant encoding
// used by the round-robin tie-breaker.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    DONE   = 2'b11
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // On a tie, serve whichever requester did not win last time.
  function automatic grant_t rr_pick(input grant_t last);
    grant_t pick;
    if (last == GRANT_D) begin
      pick = GRANT_I;
    end else begin
      pick = GRANT_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Counts BUSY cycles spent waiting for a memory acknowledge; o_tc flags the
// last permitted wait cycle (count == TIMEOUT-1).
module wait_counter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_count;

  // Clear on grant, advance while waiting, park at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (i_en && !o_tc) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single memory port with
// round-robin tie-breaking, wait-state support and an ack timeout.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  grant_t            r_grant;
  grant_t            r_last_grant;
  grant_t            w_grant_sel;
  logic              w_grant_go;
  logic              w_finish;
  logic              w_timeout;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_tc;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_err;

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant/finish decisions; ack wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    w_grant_sel = GRANT_I;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && d_req) begin
          w_grant_go  = 1'b1;
          w_grant_sel = rr_pick(r_last_grant);
        end else if (i_req) begin
          w_grant_go  = 1'b1;
          w_grant_sel = GRANT_I;
        end else if (d_req) begin
          w_grant_go  = 1'b1;
          w_grant_sel = GRANT_D;
        end else begin
          w_grant_go  = 1'b0;
        end
        if (w_grant_go) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = (w_grant_sel == GRANT_I) ? BUSY_I : BUSY_D;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end else if (w_tc) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_en    = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Memory-side registers, read-data capture, completion pulses and err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant      <= GRANT_I;
      r_last_grant <= GRANT_D;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
      r_i_rdata    <= {DATA_W{1'b0}};
      r_d_rdata    <= {DATA_W{1'b0}};
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_grant_go) begin
        r_grant   <= w_grant_sel;
        r_mem_req <= 1'b1;
        if (w_grant_sel == GRANT_D) begin
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= i_addr;
          r_mem_wdata <= {DATA_W{1'b0}};
        end
      end else if (w_finish) begin
        r_mem_req <= 1'b0;
        r_err     <= w_timeout;
        if (r_grant == GRANT_I) begin
          r_i_ready <= 1'b1;
          r_i_rdata <= w_timeout ? {DATA_W{1'b0}} : mem_rdata;
        end else begin
          r_d_ready <= 1'b1;
          if (w_timeout) begin
            r_d_rdata <= {DATA_W{1'b0}};
          end else if (!r_mem_we) begin
            r_d_rdata <= mem_rdata;
          end else begin
            r_d_rdata <= r_d_rdata;
          end
        end
      end else if (r_state == DONE) begin
        r_last_grant <= r_grant;
        r_err        <= 1'b0;
      end else begin
        r_mem_req <= r_mem_req;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign err       = r_err;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack.
REQ-002 Ports (name, direction, width, meaning) SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request, held until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_ready  out  1  one-cycle data completion pulse.
- err  out  1  timeout flag, valid only with i_ready or d_ready.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion, sampled only while mem_req = 1.

Function
REQ-003 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE.
REQ-004 IDLE, one requester active: SHALL go to BUSY_I (i_req) or BUSY_D (d_req) next cycle.
REQ-005 IDLE, both active: SHALL grant the requester not granted last (round-robin via last_grant flop).
REQ-006 At grant, address, we and wdata SHALL be latched into mem_* registers; requester inputs are ignored until DONE.
REQ-007 BUSY_x: mem_req = 1; mem_we = d_we latched (0 in BUSY_I); mem_addr and mem_wdata held stable.
REQ-008 BUSY_x with mem_ack = 1: SHALL latch mem_rdata into the granted requester's rdata register (loads and fetches only), clear err, and go to DONE.
REQ-009 Wait counter SHALL clear on grant and increment each BUSY cycle without ack.
REQ-010 Timeout: when the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to DONE with err = 1 and the granted rdata = 0.
REQ-011 DONE: SHALL pulse the granted requester's ready for exactly one cycle, update last_grant, then return to IDLE unconditionally. No grant is issued in DONE.
REQ-012 Minimum latency from req (sampled in IDLE) to ready SHALL be 2 cycles. The arbiter is not back-to-back: at most one access per 3 cycles.
REQ-013 Store completion SHALL leave d_rdata unchanged.
REQ-014 i_rdata and d_rdata SHALL hold their values until overwritten by a later completion of the same requester.
REQ-015 mem_ack asserted in IDLE or DONE SHALL be ignored.
REQ-016 A requester dropping req before ready is a protocol violation: the access SHALL still complete and pulse ready.

Reset
REQ-017 While rst = 0, asynchronously: state = IDLE; last_grant = D (fetch wins first tie); counter = 0; all outputs = 0, including mem_* registers, rdata registers, ready pulses and err.
REQ-018 Reset asserted mid-access SHALL abandon the access with no ready pulse; mem_req SHALL drop immediately.

Structure
REQ-019 The state enum (arb_state_t) and grant encoding (GRANT_I = 0, GRANT_D = 1) SHALL live in the shared package mips_pkg.
REQ-020 The timeout counter SHALL be a sub-module wait_counter (clear, enable, terminal-count output, width $clog2(TIMEOUT)); all other logic stays flat.

Verification
REQ-021 Single fetch: i_req = 1, i_addr = 0x0000_0040, mem_ack = 1 in the first BUSY cycle with mem_rdata = 0x2008_0005 -> i_ready pulses 2 cycles after req, i_rdata = 0x2008_0005, err = 0.
REQ-022 Tie: i_req and d_req both 1 from reset -> fetch served first; d_we = 1, d_addr = 0x54, d_wdata = 0x7 -> second access drives mem_we = 1, mem_addr = 0x54, mem_wdata = 0x7; d_rdata unchanged.
REQ-023 Wait states: d_req load, mem_ack delayed 5 cycles -> mem_addr stable throughout, d_ready on the 7th cycle after req.
REQ-024 Timeout: TIMEOUT = 16, mem_ack never asserted -> after 16 BUSY cycles, d_ready = 1, err = 1, d_rdata = 0.
REQ-025 Reset mid-access: rst = 0 during BUSY_D -> mem_req = 0 in the same cycle, no d_ready; the next tie grants fetch.
REQ-026 Fairness: both requests held continuously for 6 accesses -> grants alternate I, D, I, D, I, D.
